// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_renderer
// Summary  : 20x15 tile-map pixel colouring stage, 3-stage pipeline with
//            sync delay and a blank-only map write port.
//            Optional macro TILE_GRID_LINES_EN overlays a debug grid.
// Revision : 1.0  initial release
// ============================================================================
module tile_renderer #(
    parameter int TILE_COLS = 20,
    parameter int TILE_ROWS = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic        display_on,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        wr_valid,
    input  logic [8:0]  wr_addr,
    input  logic [2:0]  wr_data,
    output logic        wr_ready,
    output logic        init_done,
    output logic [11:0] rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        de_out
);

    localparam int         c_MAP_DEPTH = TILE_COLS * TILE_ROWS;
    localparam logic [8:0] c_LAST_IDX  = 9'(c_MAP_DEPTH - 1);
    localparam logic [8:0] c_DEPTH9    = 9'(c_MAP_DEPTH);
    localparam logic [4:0] c_LAST_COL  = 5'(TILE_COLS - 1);
    localparam logic [3:0] c_LAST_ROW  = 4'(TILE_ROWS - 1);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam logic [11:0] c_FLOOR = 12'h0A0;

    // ------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------
    logic [0:0] state_q, state_d;
    logic [8:0] init_idx_q, init_idx_d;
    logic [4:0] init_col_q, init_col_d;
    logic [3:0] init_row_q, init_row_d;
    logic       w_init_we;
    logic [2:0] w_init_tile;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_col_d = init_col_q;
        init_row_d = init_row_q;
        if (state_q == c_ST_INIT) begin
            init_idx_d = init_idx_q + 9'd1;
            if (init_col_q == c_LAST_COL) begin
                init_col_d = 5'd0;
                init_row_d = init_row_q + 4'd1;
            end else begin
                init_col_d = init_col_q + 5'd1;
            end
            if (init_idx_q == c_LAST_IDX) begin
                state_d = c_ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= c_ST_INIT;
            init_idx_q <= 9'd0;
            init_col_q <= 5'd0;
            init_row_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            init_col_q <= init_col_d;
            init_row_q <= init_row_d;
        end
    end

    // Border ring plus the even/even pillar grid are hard walls.
    always_comb begin
        w_init_tile = 3'd0;
        if ((init_row_q == 4'd0) || (init_row_q == c_LAST_ROW) ||
            (init_col_q == 5'd0) || (init_col_q == c_LAST_COL) ||
            (!init_row_q[0] && !init_col_q[0])) begin
            w_init_tile = 3'd1;
        end
    end

    assign w_init_we = reset && (state_q == c_ST_INIT);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic        de1_q, hs1_q, vs1_q;
    logic [4:0]  subx1_q, suby1_q;
    logic [8:0]  addr1_q;
    logic        de2_q, hs2_q, vs2_q;
    logic [4:0]  subx2_q, suby2_q;
    logic [2:0]  tile2_q;
    logic        de3_q, hs3_q, vs3_q;
    logic [11:0] rgb_q, rgb_d;

    logic [8:0]  w_row9, w_col9, w_addr;
    logic [2:0]  w_tile_rd;
    logic        w_wr_fire;

    assign w_row9 = {4'd0, y_pos[9:5]};
    assign w_col9 = {4'd0, x_pos[9:5]};
    assign w_addr = display_on ? (w_row9 * 9'd20 + w_col9) : 9'd0;

    // ------------------------------------------------------------------
    // Tile map: init walk has priority, user writes only in blanking
    // ------------------------------------------------------------------
    logic [2:0] map_q [0:c_MAP_DEPTH-1];

    assign wr_ready  = (state_q == c_ST_RUN) && !de1_q;
    assign w_wr_fire = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (w_init_we) begin
            map_q[init_idx_q] <= w_init_tile;
        end else if (w_wr_fire && (wr_addr < c_DEPTH9)) begin
            map_q[wr_addr] <= wr_data;
        end
    end

    assign w_tile_rd = (addr1_q < c_DEPTH9) ? map_q[addr1_q] : 3'd0;

    // ------------------------------------------------------------------
    // Colour generation for stage 3
    // ------------------------------------------------------------------
    logic [5:0]  w_sx6, w_sy6, w_dx, w_dy, w_dist;
    logic        w_wall_edge, w_mortar;
    logic [11:0] w_colour;

    assign w_sx6  = {1'b0, subx2_q};
    assign w_sy6  = {1'b0, suby2_q};
    assign w_dx   = (w_sx6 >= 6'd16) ? (w_sx6 - 6'd16) : (6'd16 - w_sx6);
    assign w_dy   = (w_sy6 >= 6'd16) ? (w_sy6 - 6'd16) : (6'd16 - w_sy6);
    assign w_dist = w_dx + w_dy;

    assign w_wall_edge = (subx2_q <= 5'd1) || (subx2_q >= 5'd30) ||
                         (suby2_q <= 5'd1) || (suby2_q >= 5'd30);
    assign w_mortar    = (subx2_q[3:0] == 4'd0) || (suby2_q[3:0] == 4'd0);

    always_comb begin
        w_colour = 12'h000;
        case (tile2_q)
            3'd0:    w_colour = c_FLOOR;
            3'd1:    w_colour = w_wall_edge ? 12'h444 : 12'h888;
            3'd2:    w_colour = w_mortar ? 12'hDDB : 12'hA52;
            3'd3:    w_colour = (w_dist <= 6'd12) ? 12'h000 : c_FLOOR;
            3'd4:    w_colour = 12'hF80;
            3'd5:    w_colour = 12'h00F;
            3'd6:    w_colour = 12'hF0F;
            default: w_colour = 12'hFF0;
        endcase
`ifdef TILE_GRID_LINES_EN
        if ((subx2_q == 5'd31) || (suby2_q == 5'd31)) begin
            w_colour = 12'h222;
        end
`endif
    end

    assign rgb_d = (de2_q && (state_q == c_ST_RUN)) ? w_colour : 12'h000;

    always_ff @(posedge clk) begin
        if (!reset) begin
            de1_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            subx1_q <= 5'd0;
            suby1_q <= 5'd0;
            addr1_q <= 9'd0;
            de2_q   <= 1'b0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            subx2_q <= 5'd0;
            suby2_q <= 5'd0;
            tile2_q <= 3'd0;
            de3_q   <= 1'b0;
            hs3_q   <= 1'b1;
            vs3_q   <= 1'b1;
            rgb_q   <= 12'h000;
        end else begin
            de1_q   <= display_on;
            hs1_q   <= h_sync_in;
            vs1_q   <= v_sync_in;
            subx1_q <= x_pos[4:0];
            suby1_q <= y_pos[4:0];
            addr1_q <= w_addr;
            de2_q   <= de1_q;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            subx2_q <= subx1_q;
            suby2_q <= suby1_q;
            tile2_q <= w_tile_rd;
            de3_q   <= de2_q;
            hs3_q   <= hs2_q;
            vs3_q   <= vs2_q;
            rgb_q   <= rgb_d;
        end
    end

    assign init_done  = (state_q == c_ST_RUN);
    assign rgb        = rgb_q;
    assign de_out     = de3_q;
    assign h_sync_out = hs3_q;
    assign v_sync_out = vs3_q;

endmodule
`default_nettype wire
